// File: rtl/mc_stall_controller_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mc_ctrl_pkg                                                   |
// | Purpose  : Shared encodings for the stall-aware multi-cycle controller:  |
// |            FSM state codes, RV32I opcodes, ALU / immediate / operand /   |
// |            result select encodings and the control bundle type.          |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package mc_ctrl_pkg;

  typedef logic [3:0] state_t;

  // FSM state codes; state_dbg exposes these values directly.
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADR  = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_EXEC_I   = 4'd7;
  localparam logic [3:0] S_ALU_WB   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JALR_ADR = 4'd10;
  localparam logic [3:0] S_JAL      = 4'd11;
  localparam logic [3:0] S_LUI      = 4'd12;
  localparam logic [3:0] S_ERROR    = 4'd13;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;
  localparam logic [2:0] ALU_XOR  = 3'd5;
  localparam logic [2:0] ALU_SLTU = 3'd6;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_MDR    = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;
  localparam logic [1:0] RES_IMM    = 2'd3;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       old_pc_write;
    logic       pc_write;
    logic       reg_write;
    logic [2:0] imm_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_function;
    logic [1:0] result_src;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mc_stall_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mc_stall_controller_if                                        |
// | Purpose  : Unified-memory request/ready handshake between the controller |
// |            (master) and the memory (slave).                              |
// | Ports    : mem_req, mem_write, adr_src (master->slave),                  |
// |            mem_ready (slave->master)                                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface mc_stall_controller_if;
  logic mem_req;
  logic mem_write;
  logic adr_src;
  logic mem_ready;

  modport master (output mem_req, output mem_write, output adr_src, input mem_ready);
  modport slave  (input mem_req, input mem_write, input adr_src, output mem_ready);
endinterface
`default_nettype wire

// File: rtl/mc_stall_controller_alu_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mc_alu_decoder                                                |
// | Purpose  : Combinational ALU function select for the execute and branch  |
// |            states, flagging encodings the datapath cannot execute.       |
// | Ports    : opcode/f3/f7/state in; alu_function, illegal out              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] f3,
  input  logic [6:0] f7,
  input  logic [3:0] state,
  output logic [2:0] alu_function,
  output logic       illegal
);

  // Only f7[5] distinguishes add/sub; the remaining bits are don't-care.
  logic unused_f7;
  assign unused_f7 = ^{f7[6], f7[4:0]};

  always_comb begin
    alu_function = ALU_ADD;
    illegal      = 1'b0;
    if (state == S_EXEC_R || state == S_EXEC_I) begin
      case (f3)
        3'b000:  alu_function = (opcode == OP_R && f7[5]) ? ALU_SUB : ALU_ADD;
        3'b010:  alu_function = ALU_SLT;
        3'b011:  alu_function = ALU_SLTU;
        3'b100:  alu_function = ALU_XOR;
        3'b110:  alu_function = ALU_OR;
        3'b111:  alu_function = ALU_AND;
        default: illegal      = 1'b1;   // shift encodings trap as illegal
      endcase
    end else if (state == S_BRANCH) begin
      case (f3)
        3'b000, 3'b001: alu_function = ALU_SUB;
        3'b100, 3'b101: alu_function = ALU_SLT;
        default:        illegal      = 1'b1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mc_stall_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mc_stall_controller                                           |
// | Purpose  : Main FSM of the multi-cycle RV32I core with variable-latency  |
// |            memory handshake, bus-timeout watchdog and illegal-opcode     |
// |            trapping.                                                     |
// | Ports    : clk, reset (async, active-high); opcode/f3/f7/zero decode     |
// |            inputs; mem (handshake interface, master side); datapath      |
// |            enables/selects; sticky bus_error/illegal_instr; state_dbg    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mc_stall_controller
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TMO_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [6:0]                  opcode,
  input  logic [2:0]                  f3,
  input  logic [6:0]                  f7,
  input  logic                        zero,
  mc_stall_controller_if.master       mem,
  output logic                        ir_write,
  output logic                        old_pc_write,
  output logic                        pc_write,
  output logic                        reg_write,
  output logic [2:0]                  imm_src,
  output logic [1:0]                  alu_src_a,
  output logic [1:0]                  alu_src_b,
  output logic [2:0]                  alu_function,
  output logic [1:0]                  result_src,
  output logic                        bus_error,
  output logic                        illegal_instr,
  output logic [3:0]                  state_dbg
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [3:0]       state, state_next;
  logic [TMO_W-1:0] wait_cnt, wait_cnt_next;
  logic             bus_err_q, illegal_q, set_bus_err, set_illegal;
  logic             waiting, tmo_hit;
  logic [2:0]       dec_alu_fn;
  logic             dec_illegal;
  ctrl_t            ctrl, ctrl_out;

  mc_alu_decoder u_alu_dec (
    .opcode       (opcode),
    .f3           (f3),
    .f7           (f7),
    .state        (state),
    .alu_function (dec_alu_fn),
    .illegal      (dec_illegal)
  );

  assign waiting = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // A ready in the last allowed cycle still completes normally.
  assign tmo_hit = (TIMEOUT != 0) && waiting && !mem.mem_ready && (wait_cnt == TMO_LAST);

  always_comb begin
    state_next  = state;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    case (state)
      S_FETCH:    if (mem.mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEM_ADR;
          OP_R:         state_next = S_EXEC_R;
          OP_I:         state_next = S_EXEC_I;
          OP_BR:        state_next = S_BRANCH;
          OP_JAL:       state_next = S_JAL;
          OP_JALR:      state_next = S_JALR_ADR;
          OP_LUI:       state_next = S_LUI;
          default: begin
            state_next  = S_ERROR;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADR:  state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem.mem_ready) state_next = S_MEM_WB;
      S_MEM_WB:   state_next = S_FETCH;
      S_MEM_WR:   if (mem.mem_ready) state_next = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_BRANCH: begin
        if (dec_illegal) begin
          state_next  = S_ERROR;
          set_illegal = 1'b1;
        end else begin
          state_next = (state == S_BRANCH) ? S_FETCH : S_ALU_WB;
        end
      end
      S_ALU_WB:   state_next = S_FETCH;
      S_JALR_ADR: state_next = S_JAL;
      S_JAL:      state_next = S_ALU_WB;
      S_LUI:      state_next = S_FETCH;
      default:    state_next = S_ERROR;   // ERROR and unused codes absorb
    endcase
    if (tmo_hit) begin
      state_next  = S_ERROR;
      set_bus_err = 1'b1;
    end
  end

  always_comb begin
    if (state_next != state)
      wait_cnt_next = '0;
    else if (waiting && !mem.mem_ready)
      wait_cnt_next = wait_cnt + 1'b1;
    else
      wait_cnt_next = wait_cnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (set_bus_err) bus_err_q <= 1'b1;
      if (set_illegal) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    ctrl              = '0;
    ctrl.alu_function = dec_alu_fn;
    case (state)
      S_FETCH: begin
        ctrl.mem_req      = 1'b1;
        ctrl.alu_src_b    = SRCB_FOUR;
        ctrl.result_src   = RES_ALU;
        ctrl.ir_write     = mem.mem_ready;
        ctrl.old_pc_write = mem.mem_ready;
        ctrl.pc_write     = mem.mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEM_ADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_src   = (opcode == OP_SW) ? IMM_S : IMM_I;
      end
      S_MEM_RD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.result_src = RES_MDR;
        ctrl.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.adr_src   = 1'b1;
      end
      S_EXEC_R:   ctrl.alu_src_a = SRCA_RS1;
      S_EXEC_I: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_src   = IMM_I;
      end
      S_ALU_WB:   ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a = SRCA_RS1;
        // blt/bge test the slt result: non-zero means "less than".
        case (f3)
          3'b000, 3'b101: ctrl.pc_write = zero;
          3'b001, 3'b100: ctrl.pc_write = !zero;
          default:        ctrl.pc_write = 1'b0;
        endcase
      end
      S_JALR_ADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_src   = IMM_I;
      end
      S_JAL: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_write  = 1'b1;
      end
      S_LUI: begin
        ctrl.imm_src    = IMM_U;
        ctrl.result_src = RES_IMM;
        ctrl.reg_write  = 1'b1;
      end
      default:    ctrl = '0;
    endcase
  end

  // Outputs are forced low while reset is held so an in-flight access drops at once.
  assign ctrl_out      = reset ? '0 : ctrl;
  assign mem.mem_req   = ctrl_out.mem_req;
  assign mem.mem_write = ctrl_out.mem_write;
  assign mem.adr_src   = ctrl_out.adr_src;
  assign ir_write      = ctrl_out.ir_write;
  assign old_pc_write  = ctrl_out.old_pc_write;
  assign pc_write      = ctrl_out.pc_write;
  assign reg_write     = ctrl_out.reg_write;
  assign imm_src       = ctrl_out.imm_src;
  assign alu_src_a     = ctrl_out.alu_src_a;
  assign alu_src_b     = ctrl_out.alu_src_b;
  assign alu_function  = ctrl_out.alu_function;
  assign result_src    = ctrl_out.result_src;
  assign bus_error     = bus_err_q && !reset;
  assign illegal_instr = illegal_q && !reset;
  assign state_dbg     = reset ? S_FETCH : state;

endmodule
`default_nettype wire

// File: doc/mc_stall_controller.md
Name: mc_stall_controller

Overview:
Next-generation main controller for the multi-cycle RV32I core. It replaces the fixed-timing FSM with one that talks to variable-latency unified memory through a req/ready handshake. It adds a parametrised bus-timeout watchdog, illegal-instruction trapping and blt/bge support. It sits between the datapath decode fields (opcode/f3/f7/zero) and the datapath control selects/enables, plus the memory handshake.

Parameters:
TIMEOUT, 16, max wait cycles on a memory access before bus error; 0 disables the watchdog
TMO_W, $clog2(TIMEOUT+1), width of the wait counter (minimum 1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
opcode  in  7  IR[6:0]
f3  in  3  IR[14:12]
f7  in  7  IR[31:25]
zero  in  1  ALU zero flag (combinational, current cycle)
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request, held until mem_ready
mem_write  out  1  write qualifier for mem_req
adr_src  out  1  0 = PC, 1 = ALUOut
ir_write  out  1  latch IR/MDR
old_pc_write  out  1  latch old_pc
pc_write  out  1  PC <= result
reg_write  out  1  regfile write
imm_src  out  3  0 = I, 1 = S, 2 = B, 3 = J, 4 = U
alu_src_a  out  2  0 = PC, 1 = old_pc, 2 = rs1 reg
alu_src_b  out  2  0 = rs2 reg, 1 = imm, 2 = const 4
alu_function  out  3  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 xor, 6 sltu
result_src  out  2  0 = ALUOut, 1 = MDR, 2 = ALU direct, 3 = imm
bus_error  out  1  sticky, watchdog fired
illegal_instr  out  1  sticky, unsupported encoding decoded
state_dbg  out  4  current state encoding

Behaviour:
- Clock, reset and selects:
  - One clock domain. Reset is asynchronous and active-high. It forces state to FETCH, clears the wait counter, bus_error and illegal_instr.
  - While reset is high, every output is 0, including mem_req. A reset mid-access drops mem_req/mem_write immediately.
  - All outputs are combinational from state, plus mem_ready/zero/opcode where stated. Unlisted outputs are 0 in every state.
- FETCH:
  - Asserts mem_req, adr_src=0, a=0, b=2, add, result_src=2.
  - When mem_ready=1, pulses ir_write, old_pc_write and pc_write in that cycle, then goes to DECODE. Otherwise it stays.
- DECODE:
  - a=1, b=1, add. imm_src=J if opcode=1101111, else B.
  - Next state: lw(0000011)/sw(0100011) -> MEM_ADR; R(0110011) -> EXEC_R; I-ALU(0010011) -> EXEC_I; branch(1100011) -> BRANCH; jal(1101111) -> JAL; jalr(1100111) -> JALR_ADR; lui(0110111) -> LUI; anything else -> ERROR with illegal_instr set.
- MEM_ADR: a=2, b=1, add. imm_src=I for lw -> MEM_RD; S for sw -> MEM_WR.
- MEM_RD: mem_req, adr_src=1. On mem_ready -> MEM_WB.
- MEM_WB: result_src=1, reg_write -> FETCH.
- MEM_WR: mem_req, mem_write, adr_src=1. On mem_ready -> FETCH.
- EXEC_R: a=2, b=0 -> ALU_WB.
- EXEC_I: a=2, b=1, imm I -> ALU_WB.
- ALU decode for EXEC_R/EXEC_I, by f3:
  - 000 -> add, or sub when R-type and f7[5]=1
  - 010 -> slt, 011 -> sltu, 100 -> xor, 110 -> or, 111 -> and
  - 001/101 (shifts) -> ERROR with illegal_instr.
- ALU_WB: result_src=0, reg_write -> FETCH.
- BRANCH: a=2, b=0, result_src=0. Decode by f3:
  - 000 beq: sub, pc_write=zero
  - 001 bne: sub, pc_write=!zero
  - 100 blt: slt, pc_write=!zero
  - 101 bge: slt, pc_write=zero
  - other f3 -> ERROR, illegal_instr. Valid encodings -> FETCH.
- JALR_ADR: a=2, b=1, imm I, add -> JAL.
- JAL: a=1, b=2, add, result_src=0, pc_write -> ALU_WB (rd <= old_pc+4).
- LUI: imm U, result_src=3, reg_write -> FETCH.
- Watchdog and ERROR:
  - The wait counter clears on every state change. It increments each cycle in FETCH/MEM_RD/MEM_WR with mem_ready=0.
  - If TIMEOUT!=0 and counter==TIMEOUT-1 with mem_ready=0, next state is ERROR and bus_error is set. This means TIMEOUT consecutive not-ready cycles fault.
  - mem_ready=1 in that same cycle wins: normal completion.
  - ERROR: all enables 0, absorbing until reset.
- Latency with mem_ready tied 1: R/I/jal = 4, lw = 5, sw = 4, branch = 3, jalr = 5, lui = 3 cycles.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum (FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, JALR_ADR, JAL, LUI, ERROR)
  - opcode constants
  - alu_function, imm_src, alu_src and result_src encodings
- One sub-module, mc_alu_decoder: combinational (opcode, f3, f7, state) -> alu_function plus illegal flag.

Test Plan:
- Reset release, mem_ready=1, R-type f3=000 f7=0100000 -> states FETCH, DECODE, EXEC_R (alu_function=1), ALU_WB (reg_write=1), FETCH; exactly 4 cycles.
- lw with mem_ready delayed 3 cycles in both FETCH and MEM_RD -> mem_req high throughout both waits; ir_write a single pulse coincident with the ready cycle; 11 cycles total; MEM_WB result_src=1.
- BRANCH: beq zero=1 -> pc_write=1; bne zero=1 -> pc_write=0; blt zero=0 -> pc_write=1 with alu_function=4; bge zero=0 -> pc_write=0.
- jalr -> DECODE, JALR_ADR (a=2, b=1, imm 0), JAL (pc_write=1, result_src=0), ALU_WB (reg_write=1).
- TIMEOUT=16, mem_ready held 0 in FETCH -> ERROR entered after 16 wait cycles, bus_error=1, mem_req=0. Repeat with mem_ready=1 on the 16th cycle -> DECODE, no error. TIMEOUT=0 with mem_ready held 0 for 1000 cycles -> no error.
- opcode 1111111 -> ERROR, illegal_instr=1. Async reset asserted mid-MEM_WR -> mem_req/mem_write drop the same cycle, flags clear, FETCH after release.
